ps2_host_tx: RTL and testbench

//  Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) to keyboard.

---
 rtl/ps2_host_tx.sv | 224 ++++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter. Sends one command byte to the device using open-drain
// *_oe controls: inhibit, start bit, D0..D7 LSB first, odd parity, stop bit, then the device ACK.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 2500,
  parameter int unsigned START_TIMEOUT  = 375000,
  parameter int unsigned EDGE_TIMEOUT   = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int unsigned MaxAB  = (INHIBIT_CYCLES > START_TIMEOUT) ? INHIBIT_CYCLES
                                                                    : START_TIMEOUT;
  localparam int unsigned MaxCnt = (MaxAB > EDGE_TIMEOUT) ? MaxAB : EDGE_TIMEOUT;
  localparam int unsigned CntW   = $clog2(MaxCnt + 1);

  localparam logic [CntW-1:0] InhibitLoad = CntW'(INHIBIT_CYCLES - 1);
  localparam logic [CntW-1:0] StartLoad   = CntW'(START_TIMEOUT - 1);
  localparam logic [CntW-1:0] EdgeLoad    = CntW'(EDGE_TIMEOUT - 1);
  localparam logic [CntW-1:0] CntOne      = CntW'(1);

  localparam logic [3:0] StIdle     = 4'd0;
  localparam logic [3:0] StInhibit  = 4'd1;
  localparam logic [3:0] StReq      = 4'd2;
  localparam logic [3:0] StData     = 4'd3;
  localparam logic [3:0] StParity   = 4'd4;
  localparam logic [3:0] StStop     = 4'd5;
  localparam logic [3:0] StWaitIdle = 4'd6;
  localparam logic [3:0] StDone     = 4'd7;
  localparam logic [3:0] StErr      = 4'd8;

  logic            clk_meta_q, clk_sync_q, clk_prev_q;
  logic            data_meta_q, data_sync_q;
  logic            fall;

  logic [3:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [8:0]      shift_q, shift_d;   // {parity, D7..D0}, shifted out LSB first
  logic [3:0]      bitcnt_q, bitcnt_d; // bits already driven onto the data line
  logic            clk_oe_q, clk_oe_d;
  logic            data_oe_q, data_oe_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            go_err;
  logic            expired;

  // Two-flop synchronizers on the pads; reset to the idle-high level to avoid a false fall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      clk_prev_q  <= 1'b1;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
    end else begin
      clk_meta_q  <= ps2_clk;
      clk_sync_q  <= clk_meta_q;
      clk_prev_q  <= clk_sync_q;
      data_meta_q <= ps2_data;
      data_sync_q <= data_meta_q;
    end
  end

  assign fall    = clk_prev_q & ~clk_sync_q;
  assign expired = (cnt_q == '0);

  // Next-state, counter and line-drive decisions.
  always_comb begin
    state_d   = state_q;
    cnt_d     = expired ? cnt_q : cnt_q - CntOne;
    shift_d   = shift_q;
    bitcnt_d  = bitcnt_q;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    go_err    = 1'b0;

    case (state_q)
      StIdle: begin
        if (tx_start) begin
          shift_d   = {~^tx_data, tx_data};
          bitcnt_d  = 4'd0;
          busy_d    = 1'b1;
          clk_oe_d  = 1'b1;
          // A one-cycle inhibit is also its own last cycle.
          data_oe_d = (INHIBIT_CYCLES <= 1);
          cnt_d     = InhibitLoad;
          state_d   = StInhibit;
        end
      end
      StInhibit: begin
        if (cnt_q == CntOne) data_oe_d = 1'b1;
        if (expired) begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b1;
          cnt_d     = StartLoad;
          state_d   = StReq;
        end
      end
      StReq: begin
        if (fall) begin
          data_oe_d = ~shift_q[0];
          shift_d   = {1'b0, shift_q[8:1]};
          bitcnt_d  = 4'd1;
          cnt_d     = EdgeLoad;
          state_d   = StData;
        end else if (expired) begin
          go_err = 1'b1;
        end
      end
      StData: begin
        if (fall) begin
          data_oe_d = ~shift_q[0];
          shift_d   = {1'b0, shift_q[8:1]};
          bitcnt_d  = bitcnt_q + 4'd1;
          cnt_d     = EdgeLoad;
          // Once D7 is out, the bit now being driven is parity.
          if (bitcnt_q == 4'd8) state_d = StParity;
        end else if (expired) begin
          go_err = 1'b1;
        end
      end
      StParity: begin
        if (fall) begin
          data_oe_d = 1'b0;
          cnt_d     = EdgeLoad;
          state_d   = StStop;
        end else if (expired) begin
          go_err = 1'b1;
        end
      end
      StStop: begin
        if (fall) begin
          if (!data_sync_q) begin
            cnt_d   = EdgeLoad;
            state_d = StWaitIdle;
          end else begin
            go_err = 1'b1;
          end
        end else if (expired) begin
          go_err = 1'b1;
        end
      end
      StWaitIdle: begin
        if (clk_sync_q && data_sync_q) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          cnt_d   = '0;
          state_d = StDone;
        end else if (expired) begin
          go_err = 1'b1;
        end
      end
      StDone: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
      StErr: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
      default: begin
        cnt_d     = '0;
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        busy_d    = 1'b0;
        state_d   = StIdle;
      end
    endcase

    if (go_err) begin
      err_d     = 1'b1;
      busy_d    = 1'b0;
      clk_oe_d  = 1'b0;
      data_oe_d = 1'b0;
      cnt_d     = '0;
      state_d   = StErr;
    end
  end

  // State and registered outputs; reset releases both lines immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      shift_q   <= '0;
      bitcnt_q  <= '0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      bitcnt_q  <= bitcnt_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign tx_busy     = busy_q;
  assign tx_done     = done_q;
  assign tx_error    = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a simple PS/2 device model on an open-drain bus.
module tb_ps2_host_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_start = 1'b0;
  logic       tx_busy, tx_done, tx_error;
  logic       ps2_clk, ps2_data, ps2_clk_oe, ps2_data_oe;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int done_idle_cnt = 0;
  int both_cnt = 0;

  assign ps2_clk  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data = ~(ps2_data_oe | dev_data_low);

  always #5 clk = ~clk;

  ps2_host_tx #(
    .INHIBIT_CYCLES(20),
    .START_TIMEOUT (400),
    .EDGE_TIMEOUT  (200)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .tx_error   (tx_error),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe)
  );

  // Pulse bookkeeping, so results are not missed while the device model is busy.
  always_ff @(posedge clk) begin
    if (tx_done) done_cnt <= done_cnt + 1;
    if (tx_error) err_cnt <= err_cnt + 1;
    if (tx_done && !tx_busy) done_idle_cnt <= done_idle_cnt + 1;
    if (tx_done && tx_error) both_cnt <= both_cnt + 1;
  end

  task automatic start_tx(input logic [7:0] d);
    @(negedge clk);
    tx_data  = d;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
  endtask

  // Counts cycles with ps2_clk_oe high; returns at the first sample in REQ.
  task automatic measure_inhibit(output int n, output int dn);
    n  = 0;
    dn = 0;
    while (ps2_clk_oe && n < 1000) begin
      if (ps2_data_oe) dn++;
      n++;
      @(negedge clk);
    end
  endtask

  // Device: nfalls clock pulses of 40 low / 40 high; samples data just after each rise.
  // bits = {stop, parity, D7..D0, start}.
  task automatic dev_frame(input int nfalls, input bit ack, output logic [10:0] bits);
    bits    = '0;
    bits[0] = ps2_data;
    repeat (50) @(negedge clk);
    for (int k = 1; k <= nfalls; k++) begin
      if (k == 11) begin
        dev_data_low = ack;
        repeat (20) @(negedge clk);
      end
      dev_clk_low = 1'b1;
      repeat (40) @(negedge clk);
      dev_clk_low = 1'b0;
      @(negedge clk);
      if (k <= 10) bits[k] = ps2_data;
      repeat (39) @(negedge clk);
      if (k == 11) dev_data_low = 1'b0;
    end
  endtask

  // Full transaction; ndone/nerr are pulse-cycle counts seen during it.
  task automatic send_frame(input logic [7:0] d, input bit ack, output logic [10:0] bits,
                            output int inh, output int dinh, output int ndone, output int nerr);
    int d0, e0, w;
    d0 = done_cnt;
    e0 = err_cnt;
    start_tx(d);
    measure_inhibit(inh, dinh);
    dev_frame(11, ack, bits);
    w = 0;
    while (done_cnt == d0 && err_cnt == e0 && w < 300) begin
      @(negedge clk);
      w++;
    end
    repeat (3) @(negedge clk);
    ndone = done_cnt - d0;
    nerr  = err_cnt - e0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({ps2_clk_oe, ps2_data_oe, tx_busy, tx_done, tx_error} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 00000",
               {ps2_clk_oe, ps2_data_oe, tx_busy, tx_done, tx_error});
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_send_ed();
    logic [10:0] bits;
    int inh, dinh, nd, ne, di0;
    di0 = done_idle_cnt;
    send_frame(8'hED, 1'b1, bits, inh, dinh, nd, ne);
    checks++;
    if (inh !== 20) begin errors++; $display("FAIL inhibit_len: got %0d expected 20", inh); end
    checks++;
    if (dinh !== 1) begin errors++; $display("FAIL inhibit_data: got %0d expected 1", dinh); end
    checks++;
    if (bits !== 11'h7DA) begin errors++; $display("FAIL frame_ed: got %h expected 7da", bits); end
    checks++;
    if (nd !== 1 || ne !== 0) begin
      errors++;
      $display("FAIL done_ed: got done=%0d err=%0d expected done=1 err=0", nd, ne);
    end
    checks++;
    if (done_idle_cnt - di0 !== 1) begin
      errors++;
      $display("FAIL busy_at_done: got %0d expected 1", done_idle_cnt - di0);
    end
  endtask

  task automatic test_parity();
    logic [7:0]  data_v [3] = '{8'hF4, 8'h00, 8'hFF};
    logic [10:0] exp_v  [3] = '{11'h5E8, 11'h600, 11'h7FE};
    logic [10:0] bits;
    int inh, dinh, nd, ne;
    for (int i = 0; i < 3; i++) begin
      send_frame(data_v[i], 1'b1, bits, inh, dinh, nd, ne);
      checks++;
      if (bits !== exp_v[i]) begin
        errors++;
        $display("FAIL frame_%h: got %h expected %h", data_v[i], bits, exp_v[i]);
      end
      checks++;
      if (nd !== 1 || ne !== 0) begin
        errors++;
        $display("FAIL done_%h: got done=%0d err=%0d expected 1/0", data_v[i], nd, ne);
      end
    end
  endtask

  task automatic test_start_timeout();
    int inh, dinh, n;
    start_tx(8'h55);
    measure_inhibit(inh, dinh);
    n = 0;
    while (!tx_error && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n !== 400) begin errors++; $display("FAIL start_timeout: got %0d expected 400", n); end
    checks++;
    if ({ps2_clk_oe, ps2_data_oe, tx_busy, tx_done} !== 4'b0) begin
      errors++;
      $display("FAIL start_timeout_lines: got %b expected 0000",
               {ps2_clk_oe, ps2_data_oe, tx_busy, tx_done});
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_no_ack();
    logic [10:0] bits;
    int inh, dinh, nd, ne;
    send_frame(8'hA5, 1'b0, bits, inh, dinh, nd, ne);
    checks++;
    if (nd !== 0 || ne !== 1) begin
      errors++;
      $display("FAIL no_ack: got done=%0d err=%0d expected done=0 err=1", nd, ne);
    end
    send_frame(8'hFF, 1'b1, bits, inh, dinh, nd, ne);
    checks++;
    if (bits !== 11'h7FE || nd !== 1 || ne !== 0) begin
      errors++;
      $display("FAIL after_no_ack: got frame=%h done=%0d err=%0d expected 7fe/1/0", bits, nd, ne);
    end
  endtask

  task automatic test_edge_timeout();
    logic [10:0] bits;
    int inh, dinh, n;
    start_tx(8'h3C);
    measure_inhibit(inh, dinh);
    dev_frame(4, 1'b0, bits);
    dev_clk_low = 1'b1;
    n = 0;
    while (!tx_error && n < 1000) begin
      @(negedge clk);
      n++;
      if (n == 40) dev_clk_low = 1'b0;
    end
    dev_clk_low = 1'b0;
    checks++;
    if (n !== 203) begin errors++; $display("FAIL edge_timeout: got %0d expected 203", n); end
    checks++;
    if ({ps2_clk_oe, ps2_data_oe, tx_busy} !== 3'b0) begin
      errors++;
      $display("FAIL edge_timeout_lines: got %b expected 000", {ps2_clk_oe, ps2_data_oe, tx_busy});
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_busy_and_async_reset();
    logic [10:0] bits;
    int inh, dinh;
    start_tx(8'h92);
    measure_inhibit(inh, dinh);
    tx_data  = 8'h6D;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    dev_frame(3, 1'b0, bits);
    checks++;
    if (bits[3:0] !== 4'b0100) begin
      errors++;
      $display("FAIL busy_ignore: got %b expected 0100", bits[3:0]);
    end
    checks++;
    if ({tx_busy, ps2_data_oe} !== 2'b11) begin
      errors++;
      $display("FAIL mid_data_state: got %b expected 11", {tx_busy, ps2_data_oe});
    end
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({ps2_clk_oe, ps2_data_oe, tx_busy} !== 3'b0) begin
      errors++;
      $display("FAIL async_reset: got %b expected 000", {ps2_clk_oe, ps2_data_oe, tx_busy});
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_recover();
    logic [10:0] bits;
    int inh, dinh, nd, ne;
    send_frame(8'hED, 1'b1, bits, inh, dinh, nd, ne);
    checks++;
    if (bits !== 11'h7DA || nd !== 1 || ne !== 0 || inh !== 20) begin
      errors++;
      $display("FAIL recover: got frame=%h done=%0d err=%0d inh=%0d expected 7da/1/0/20",
               bits, nd, ne, inh);
    end
    checks++;
    if (both_cnt !== 0) begin
      errors++;
      $display("FAIL done_err_exclusive: got %0d expected 0", both_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_send_ed();
    test_parity();
    test_start_timeout();
    test_no_ack();
    test_edge_timeout();
    test_busy_and_async_reset();
    test_recover();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
